// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between decode/fetch, the sequential ALU
// and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op_code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, op_code, out_ready,
    input  in_ready, out_valid, alu_out, zero, negative, carry, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, op_code, out_ready,
    output in_ready, out_valid, alu_out, zero, negative, carry, overflow, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides and registered NZCV flags.
// Shifts move one bit per cycle; MUL is shift-add, one multiplier bit per cycle.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// EXEC  | iterating a shift or multiply, cnt_q cycles remain
// DONE  | result/flags valid, held until out_ready
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst,
  seq_alu_if.slave bus
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_OR     = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_PASS_B = 4'd6;
  localparam logic [3:0] OP_SLL    = 4'd7;
  localparam logic [3:0] OP_SRL    = 4'd8;
  localparam logic [3:0] OP_SRA    = 4'd9;
  localparam logic [3:0] OP_MUL    = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   work_q, work_nx;
  logic [2*WIDTH-1:0] prod_q, prod_nx;
  logic [WIDTH:0]     prod_sum;
  logic [CW-1:0]      cnt_q;
  logic               sh_out;

  logic [WIDTH-1:0]   res_q;
  logic               zero_q, neg_q, carry_q, ovf_q;

  logic               in_ready, accept, long_op, is_shift, exec_last;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_full, sub_full;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;

  logic               res_ld;
  logic [WIDTH-1:0]   res_d;
  logic               c_d, v_d;

  assign shamt     = bus.b[SHW-1:0];
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign is_shift  = (bus.op_code == OP_SLL) || (bus.op_code == OP_SRL) ||
                     (bus.op_code == OP_SRA);
  assign long_op   = (bus.op_code == OP_MUL) || (is_shift && (shamt != '0));
  assign exec_last = (state_q == EXEC) && (cnt_q == CW'(1));

  assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_full = {1'b0, bus.a} - {1'b0, bus.b};

  // Ops that finish at the accept edge; a zero-distance shift passes a through.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op_code)
      OP_PASS_A: sc_res = bus.a;
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (add_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = ~sub_full[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:    sc_res = bus.a & bus.b;
      OP_OR:     sc_res = bus.a | bus.b;
      OP_XOR:    sc_res = bus.a ^ bus.b;
      OP_PASS_B: sc_res = bus.b;
      OP_SLL, OP_SRL, OP_SRA: sc_res = bus.a;
      default:   sc_res = '0;
    endcase
  end

  always_comb begin
    work_nx = work_q;
    sh_out  = 1'b0;
    case (op_q)
      OP_SLL: begin
        work_nx = {work_q[WIDTH-2:0], 1'b0};
        sh_out  = work_q[WIDTH-1];
      end
      OP_SRL: begin
        work_nx = {1'b0, work_q[WIDTH-1:1]};
        sh_out  = work_q[0];
      end
      OP_SRA: begin
        work_nx = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_out  = work_q[0];
      end
      default: ;
    endcase
  end

  // prod_q = {partial sum, remaining multiplier bits}; work_q holds the multiplicand.
  assign prod_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, work_q} : {(WIDTH+1){1'b0}});
  assign prod_nx  = {prod_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    res_ld = 1'b0;
    res_d  = sc_res;
    c_d    = sc_c;
    v_d    = sc_v;
    if (accept && !long_op) begin
      res_ld = 1'b1;
    end else if (exec_last) begin
      res_ld = 1'b1;
      v_d    = 1'b0;
      if (op_q == OP_MUL) begin
        res_d = prod_nx[WIDTH-1:0];
        c_d   = |prod_nx[2*WIDTH-1:WIDTH];
      end else begin
        res_d = work_nx;
        c_d   = sh_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = long_op ? EXEC : DONE;
      EXEC: if (exec_last) state_d = DONE;
      DONE: begin
        if (accept)             state_d = long_op ? EXEC : DONE;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      work_q <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.op_code;
      work_q <= bus.a;
      prod_q <= {{WIDTH{1'b0}}, bus.b};
      cnt_q  <= (bus.op_code == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt};
    end else if (state_q == EXEC) begin
      work_q <= (op_q == OP_MUL) ? work_q : work_nx;
      prod_q <= prod_nx;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (res_ld) begin
      res_q   <= res_d;
      zero_q  <= (res_d == '0);
      neg_q   <= res_d[WIDTH-1];
      carry_q <= c_d;
      ovf_q   <= v_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == EXEC);
  assign bus.alu_out   = res_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule
